// File: rtl/cpu_step_ctrl_if.sv
// Board-side signal bundle for the CPU step controller: slow clock, operator
// controls and halt in; clock-enable, mode and pulse count out.
interface cpu_step_ctrl_if #(
  parameter int COUNT_W = 32
);
  logic               slow_clk_in;
  logic               run_sw;
  logic               step_btn;
  logic               cpu_halted;
  logic               cpu_en;
  logic [1:0]         mode;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output slow_clk_in, run_sw, step_btn, cpu_halted,
    input  cpu_en, mode, instr_count
  );

  modport slave (
    input  slow_clk_in, run_sw, step_btn, cpu_halted,
    output cpu_en, mode, instr_count
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Turns the divided slow clock into one-cycle CPU clock-enable pulses, with
// free-run, debounced single-step and halt modes, and counts issued pulses.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_W         = 32
) (
  input  logic           clock_in,
  input  logic           rst_n,
  cpu_step_ctrl_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  // Two-flop synchronisers: bit 0 is the run switch, bit 1 the step button.
  logic [1:0] async_in;
  logic [1:0] sync_s;
  assign async_in = {bus.step_btn, bus.run_sw};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic meta_reg;
    logic sync_reg;
    always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= async_in[gi];
        sync_reg <= meta_reg;
      end
    end
    assign sync_s[gi] = sync_reg;
  end

  logic run_s;
  logic btn_s;
  assign run_s = sync_s[0];
  assign btn_s = sync_s[1];

  logic            slow_q_reg;
  logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
  logic            btn_db_reg, btn_db_next;
  logic            btn_db_q_reg;
  state_t          state_reg, state_next;
  logic            cpu_en_reg, cpu_en_next;
  logic [COUNT_W-1:0] count_reg;

  logic tick;
  logic step_req;
  assign tick     = bus.slow_clk_in & ~slow_q_reg;
  assign step_req = btn_db_reg & ~btn_db_q_reg;

  // A new button level must persist for DEBOUNCE_CYCLES samples to be taken.
  always_comb begin
    db_cnt_next = '0;
    btn_db_next = btn_db_reg;
    if (btn_s != btn_db_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        btn_db_next = btn_s;
      end else begin
        db_cnt_next = db_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cpu_en_next = tick & ((state_reg == RUN) | (state_reg == STEP)) & ~bus.cpu_halted;
    case (state_reg)
      IDLE: begin
        if (bus.cpu_halted)  state_next = HALT;
        else if (run_s)      state_next = RUN;
        else if (step_req)   state_next = STEP;
      end
      RUN: begin
        if (bus.cpu_halted)  state_next = HALT;
        else if (!run_s)     state_next = IDLE;
      end
      // Extra step requests arriving here are simply not looked at.
      STEP: begin
        if (bus.cpu_halted)  state_next = HALT;
        else if (tick)       state_next = IDLE;
      end
      HALT: begin
        if (!bus.cpu_halted) state_next = IDLE;
      end
      default:               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      slow_q_reg   <= 1'b0;
      db_cnt_reg   <= '0;
      btn_db_reg   <= 1'b0;
      btn_db_q_reg <= 1'b0;
      state_reg    <= IDLE;
      cpu_en_reg   <= 1'b0;
      count_reg    <= '0;
    end else begin
      slow_q_reg   <= bus.slow_clk_in;
      db_cnt_reg   <= db_cnt_next;
      btn_db_reg   <= btn_db_next;
      btn_db_q_reg <= btn_db_reg;
      state_reg    <= state_next;
      cpu_en_reg   <= cpu_en_next;
      // Counted on the edge that raises cpu_en, so the count includes the
      // pulse currently visible; wraps silently.
      count_reg    <= count_reg + COUNT_W'(cpu_en_next);
    end
  end

  assign bus.cpu_en      = cpu_en_reg;
  assign bus.mode        = state_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Sits directly downstream of the clock divider and upstream of the KGP_RISC datapath.
- Converts the divider's slow square wave into single-cycle clock-enable pulses for the CPU, which runs entirely on the fast board clock.
- Gives the board three operating modes: free-run (run switch), single-step (debounced push-button) and halt (CPU halt signal).
- Also counts the enable pulses it has issued, for display.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive clock_in cycles the synchronised button must hold a new level before it is accepted; minimum 2.
- COUNT_W, 32, width of instr_count.

Ports:
- clock_in  input  1  board clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- slow_clk_in  input  1  divided clock from the clock divider; already registered in the clock_in domain, so it is not synchronised.
- run_sw  input  1  run switch, asynchronous; 1 = free-run.
- step_btn  input  1  single-step push-button, asynchronous and bouncy.
- cpu_halted  input  1  CPU halt indication, synchronous to clock_in.
- cpu_en  output  1  CPU clock-enable, exactly one clock_in cycle wide per step.
- mode  output  2  current state: 00 IDLE, 01 RUN, 10 STEP, 11 HALT.
- instr_count  output  COUNT_W  number of cpu_en pulses issued.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, so mode = 00.
  - cpu_en = 0 and instr_count = 0.
  - All synchroniser, debounce and edge registers = 0.
  - Reset asserted mid-step clears everything immediately; a pending step is lost.
- Synchronisers: run_sw and step_btn each pass through two flops, giving run_s and btn_s.
- Tick detection:
  - slow_q is slow_clk_in delayed by one register.
  - tick = slow_clk_in & ~slow_q, one cycle per slow rising edge.
- Debounce:
  - While btn_s differs from btn_db, db_cnt increments.
  - When db_cnt reaches DEBOUNCE_CYCLES-1, btn_db takes btn_s and db_cnt clears.
  - When btn_s equals btn_db, db_cnt clears.
  - step_req is one cycle long, on the rising edge of btn_db only; release is ignored.
- FSM (registered, evaluated every clock_in cycle; priority in the order listed):
  - IDLE:
    - cpu_halted -> HALT.
    - Else run_s -> RUN.
    - Else step_req -> STEP.
  - RUN:
    - cpu_halted -> HALT.
    - Else !run_s -> IDLE.
    - cpu_en is driven from tick.
  - STEP:
    - cpu_halted -> HALT, with no pulse issued.
    - Else on tick, issue one pulse and go to IDLE.
    - Further step_req pulses while in STEP are dropped, not queued.
  - HALT:
    - cpu_en is held at 0.
    - !cpu_halted -> IDLE.
- cpu_en is registered: cpu_en <= tick & (state==RUN | state==STEP) & !cpu_halted.
  - The pulse therefore appears in the cycle after the first cycle in which slow_clk_in reads 1.
  - The pulse is never longer than one cycle and never back-to-back, because a tick needs a 0 before its 1.
- Simultaneous events:
  - tick and cpu_halted in the same cycle: no pulse.
  - tick in the same cycle that IDLE->STEP is taken: no pulse; the step waits for the next tick.
  - run_s falling on a tick cycle in RUN: the pulse is still issued, because it is based on the current state.
- instr_count increments in the cycle cpu_en is 1 (same edge that registers cpu_en=1 plus one, i.e. count reflects pulses seen); it wraps from all-ones to 0 with no flag.
- mode is a direct decode of the state register, so it is glitch-free.

Test Plan (bench drives slow_clk_in as a 4-high/4-low square wave; DEBOUNCE_CYCLES=4):
- Reset, then run_sw=1 for 40 cycles -> mode=01 after 3 cycles; cpu_en pulses exactly once per 8 cycles, each 1 cycle wide, one cycle after each slow_clk_in rise; instr_count = 4 or 5 matching pulse count.
- run_sw=0, step_btn pressed clean for 10 cycles -> mode=10, then exactly one cpu_en pulse at the next slow rise, mode returns 00, instr_count +1.
- step_btn bouncing (toggling every 2 cycles for 12 cycles, then stable high) -> exactly one step_req and exactly one cpu_en pulse; a second press inside STEP produces no extra pulse.
- In RUN, raise cpu_halted on a cycle where tick=1 -> no cpu_en pulse that cycle; mode=11; cpu_en stays 0 despite later ticks; drop cpu_halted -> mode=00.
- Preload instr_count near wrap (COUNT_W=4, run 17 pulses) -> count goes 15 -> 0 and keeps counting.
- Assert rst_n low asynchronously mid-STEP between clock edges -> cpu_en, instr_count and mode are 0 immediately, and no pulse follows after release until a new request.
